// File: rtl/char_buffer_arbiter.sv
// Single-port arbiter for the text-mode character RAM. Display fetches win over the
// clear engine, which wins over the chatbot writer; the winner drives the RAM directly.
module char_buffer_arbiter #(
  parameter int             AW        = 12,
  parameter int             DW        = 8,
  parameter int             DEPTH     = 2400,
  parameter logic [DW-1:0]  CLR_VALUE = 8'h20
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic          disp_gnt_o,
  output logic [DW-1:0] disp_rdata_o,
  output logic          disp_rvalid_o,
  input  logic          wr_req_i,
  input  logic          wr_we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_wdata_i,
  output logic          wr_ack_o,
  output logic [DW-1:0] wr_rdata_o,
  output logic          wr_rvalid_o,
  input  logic          clr_start_i,
  output logic          clr_busy_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          disp_rvalid_q, disp_oor_q;
  logic          wr_rvalid_q, wr_oor_q;
  logic          disp_in_range, wr_in_range;

  assign disp_in_range = {1'b0, disp_addr_i} < DEPTH_W;
  assign wr_in_range   = {1'b0, wr_addr_i} < DEPTH_W;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    disp_gnt_o  = 1'b0;
    wr_ack_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!reset_i) begin
      if (disp_req_i) begin
        disp_gnt_o = 1'b1;
        mem_en_o   = disp_in_range;
        mem_addr_o = disp_addr_i;
      end else if (state_q == CLEAR) begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = clr_addr_q;
        mem_wdata_o = CLR_VALUE;
        // The clear pointer only moves on cycles the engine actually owns the RAM.
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end else if (wr_req_i) begin
        wr_ack_o    = 1'b1;
        mem_en_o    = wr_in_range;
        mem_we_o    = wr_in_range & wr_we_i;
        mem_addr_o  = wr_addr_i;
        mem_wdata_o = wr_wdata_i;
      end
      if (state_q == IDLE && clr_start_i) begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      clr_addr_q    <= '0;
      disp_rvalid_q <= 1'b0;
      disp_oor_q    <= 1'b0;
      wr_rvalid_q   <= 1'b0;
      wr_oor_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      disp_rvalid_q <= disp_gnt_o;
      disp_oor_q    <= ~disp_in_range;
      wr_rvalid_q   <= wr_ack_o & ~wr_we_i;
      wr_oor_q      <= ~wr_in_range;
    end
  end

  // Out-of-range reads never touched the RAM, so their data is forced to zero.
  assign disp_rvalid_o = disp_rvalid_q & ~reset_i;
  assign disp_rdata_o  = (disp_rvalid_o && !disp_oor_q) ? mem_rdata_i : '0;
  assign wr_rvalid_o   = wr_rvalid_q & ~reset_i;
  assign wr_rdata_o    = (wr_rvalid_o && !wr_oor_q) ? mem_rdata_i : '0;
  assign clr_busy_o    = (state_q == CLEAR);

endmodule
